cla_add_sequencer: RTL and testbench

- Multi-cycle controller that shares one external 16-bit carry-lookahead adder slice between two requesters (0 = ALU, 1 = branch-target unit).
- Performs WIDTH-bit add/subtract by sequencing the slice low-to-high, one pass per cycle, and latching the ripple carry between passes.
- Sits between the execute-stage requesters and the single 16-bit CLA adder instance.

---
 rtl/cla_add_sequencer_pkg.sv | 18 +
 rtl/cla_add_sequencer_if.sv | 51 +++++
 rtl/cla_add_sequencer_rr_arbiter2.sv | 35 +++
 rtl/cla_add_sequencer.sv | 135 +++++++++++++
 tb/tb_cla_add_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_add_sequencer_pkg.sv
// rtl/cla_add_sequencer_pkg.sv - shared types and constants for the add sequencer
// Purpose: FSM state encoding, default slice width, requester id width and ids.
// Ports: none (package addseq_pkg).
package addseq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_DEF = 16;
  localparam int ID_W      = 1;

  localparam logic [ID_W-1:0] REQ_ALU = 1'b0;
  localparam logic [ID_W-1:0] REQ_BTU = 1'b1;

endpackage

// File: rtl/cla_add_sequencer_if.sv
// rtl/cla_add_sequencer_if.sv - request, adder-slice and response bundle
// Purpose: groups the sequencer's handshake and shared-adder signals.
// Ports: req_valid/req_ready/req_sub/req_a0/req_b0/req_a1/req_b1 (requests),
//   add_a/add_b/add_cin/add_sum/add_cout (shared slice),
//   rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout (response),
//   rsp_zero/rsp_ovf only with CLA_ADD_SEQ_FLAGS_EN.
// Modports: master = requesters/consumer/adder side, slave = sequencer.
interface cla_add_sequencer_if
  import addseq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_DEF
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_sub;
  logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [SLICE-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             rsp_valid, rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
`ifdef CLA_ADD_SEQ_FLAGS_EN
  logic             rsp_zero, rsp_ovf;
`endif

  modport master (
`ifdef CLA_ADD_SEQ_FLAGS_EN
    input  rsp_zero, rsp_ovf,
`endif
    output req_valid, req_sub, req_a0, req_b0, req_a1, req_b1,
    input  req_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
    output rsp_ready
  );

  modport slave (
`ifdef CLA_ADD_SEQ_FLAGS_EN
    output rsp_zero, rsp_ovf,
`endif
    input  req_valid, req_sub, req_a0, req_b0, req_a1, req_b1,
    output req_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout,
    input  rsp_ready
  );
endinterface

// File: rtl/cla_add_sequencer_rr_arbiter2.sv
// rtl/cla_add_sequencer_rr_arbiter2.sv - two-way round-robin arbiter
// Purpose: grants one of two requesters; on a tie the one not granted last wins.
// Ports: clk, rst_n (async active-low), req[1:0] in, accept in (grant taken),
//   grant[1:0] out (one-hot, zero when no request), grant_id out.
module rr_arbiter2
  import addseq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req,
  input  logic            accept,
  output logic [1:0]      grant,
  output logic [ID_W-1:0] grant_id
);

  // Id of the last accepted requester; resets to BTU so ALU wins the first tie.
  logic [ID_W-1:0] last_q;

  always_comb begin
    grant_id = (req == 2'b11) ? ~last_q : req[1];
    grant    = 2'b00;
    if (req != 2'b00) begin
      grant = (grant_id == REQ_BTU) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_BTU;
    end else if (accept) begin
      last_q <= grant_id;
    end
  end

endmodule

// File: rtl/cla_add_sequencer.sv
// rtl/cla_add_sequencer.sv - WIDTH-bit add/sub sequenced over one shared CLA slice
// Purpose: arbitrates two requesters, drives NPASS low-to-high passes through
//   the external SLICE-bit adder, latches the ripple carry between passes and
//   holds the result until the consumer takes it. WIDTH must be a multiple of SLICE.
// Ports: clk, rst_n (async active-low); bus (cla_add_sequencer_if.slave):
//   req_* request handshake, add_* shared slice, rsp_* response handshake.
// Option: CLA_ADD_SEQ_FLAGS_EN adds registered rsp_zero and rsp_ovf.
module cla_add_sequencer
  import addseq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_DEF
) (
  input logic                clk,
  input logic                rst_n,
  cla_add_sequencer_if.slave bus
);

  localparam int NPASS = WIDTH / SLICE;
  localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(NPASS - 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    pass_q;
  logic             carry_q, sub_q;
  logic [ID_W-1:0]  id_q, grant_id;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_sub;
  logic [1:0]       grant, req_ready;
  logic             accept;
  logic [SLICE-1:0] add_a, add_b;
  logic             add_cin;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req_valid),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_a   = (grant_id == REQ_BTU) ? bus.req_a1 : bus.req_a0;
  assign sel_b   = (grant_id == REQ_BTU) ? bus.req_b1 : bus.req_b0;
  assign sel_sub = bus.req_sub[grant_id];

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = 2'b00;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is gated by rst_n so it reads 0 while reset is held.
        req_ready = rst_n ? grant : 2'b00;
        accept    = (grant != 2'b00);
        if (accept) state_d = PASS;
      end
      PASS: begin
        add_a   = a_q[int'(pass_q)*SLICE +: SLICE];
        add_b   = b_q[int'(pass_q)*SLICE +: SLICE];
        // Subtraction's +1 enters as carry-in of the lowest slice.
        add_cin = (pass_q == '0) ? sub_q : carry_q;
        if (pass_q == LAST_PASS) state_d = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pass_q  <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        a_q    <= sel_a;
        b_q    <= sel_b ^ {WIDTH{sel_sub}};
        sub_q  <= sel_sub;
        id_q   <= grant_id;
        pass_q <= '0;
      end else if (state_q == PASS) begin
        sum_q[int'(pass_q)*SLICE +: SLICE] <= bus.add_sum;
        carry_q <= bus.add_cout;
        pass_q  <= (pass_q == LAST_PASS) ? '0 : pass_q + PW'(1);
      end
    end
  end

`ifdef CLA_ADD_SEQ_FLAGS_EN
  logic             zero_q, ovf_q;
  logic [WIDTH-1:0] sum_next;

  // Full result as it will look once the current slice is written.
  always_comb begin
    sum_next = sum_q;
    sum_next[int'(pass_q)*SLICE +: SLICE] = bus.add_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == PASS && pass_q == LAST_PASS) begin
      zero_q <= (sum_next == '0);
      ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (bus.add_sum[SLICE-1] != a_q[WIDTH-1]);
    end
  end

  assign bus.rsp_zero = zero_q;
  assign bus.rsp_ovf  = ovf_q;
`endif

  assign bus.req_ready = req_ready;
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;
  assign bus.add_cin   = add_cin;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = carry_q;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// tb/tb_cla_add_sequencer.sv - self-checking bench for cla_add_sequencer
module tb_cla_add_sequencer;
  import addseq_pkg::*;

  localparam int WIDTH = 32;
  localparam int SLICE = 16;
  localparam int NPASS = WIDTH / SLICE;

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic        has_lit;
    logic [31:0] lit_sum;
    logic        lit_cout, lit_zero, lit_ovf;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_add_sequencer_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bus ();

  cla_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The shared 16-bit adder slice.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

  int n_cmp = 0;
  int n_bad = 0;

  op_t q0[$];
  op_t q1[$];
  op_t cur_op [2];
  int  acc_cnt [2];
  int  seen [2];
  bit  rand_gap;
  int  rr_mode;

  // Reference model state: one operation in flight, cycles since acceptance.
  bit  m_busy;
  int  m_cyc;
  bit  m_last;
  bit  m_id;
  op_t m_op;
  int  n_rsp;
  bit  grant_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                             input logic hl, input logic [31:0] ls, input logic lc,
                             input logic lz, input logic lo);
    op_t o;
    o.a = a; o.b = b; o.sub = sub; o.has_lit = hl;
    o.lit_sum = ls; o.lit_cout = lc; o.lit_zero = lz; o.lit_ovf = lo;
    return o;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Compare process: checks every output against the model each cycle.
  logic [1:0]         mv, er;
  bit                 mg;
  int                 mk_i;
  logic [63:0]        bp, mask, a64;
  logic [31:0]        exp_sum;
  logic               exp_cout;
  logic signed [63:0] sa, sb, sres;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_cyc = 0; m_last = 1;
      end else begin
        mv = bus.req_valid;
        mg = (mv == 2'b11) ? !m_last : mv[1];
        er = (m_busy || mv == 2'b00) ? 2'b00 : (mg ? 2'b10 : 2'b01);
        check("req_ready", bus.req_ready, er);

        a64 = {32'd0, m_op.a};
        bp  = {32'd0, (m_op.sub ? ~m_op.b : m_op.b)};
        if (m_busy && m_cyc <= NPASS) begin
          mk_i = m_cyc - 1;
          mask = (64'd1 << (mk_i * SLICE)) - 64'd1;
          check("add_a", bus.add_a, (a64 >> (mk_i * SLICE)) & 64'hFFFF);
          check("add_b", bus.add_b, (bp >> (mk_i * SLICE)) & 64'hFFFF);
          check("add_cin", bus.add_cin,
                ((a64 & mask) + (bp & mask) + {63'd0, m_op.sub}) >> (mk_i * SLICE));
        end else begin
          check("add_a_idle", bus.add_a, 0);
          check("add_b_idle", bus.add_b, 0);
          check("add_cin_idle", bus.add_cin, 0);
        end

        check("rsp_valid", bus.rsp_valid, m_busy && m_cyc > NPASS);
        if (m_busy && m_cyc > NPASS) begin
          exp_sum  = m_op.sub ? m_op.a - m_op.b : m_op.a + m_op.b;
          exp_cout = m_op.sub ? (m_op.a >= m_op.b) : ((a64 + {32'd0, m_op.b}) >> 32) != 0;
          check("rsp_sum", bus.rsp_sum, exp_sum);
          check("rsp_cout", bus.rsp_cout, exp_cout);
          check("rsp_id", bus.rsp_id, m_id);
`ifdef CLA_ADD_SEQ_FLAGS_EN
          sa = {{32{m_op.a[31]}}, m_op.a};
          sb = {{32{m_op.b[31]}}, m_op.b};
          sres = m_op.sub ? sa - sb : sa + sb;
          check("rsp_zero", bus.rsp_zero, exp_sum == 0);
          check("rsp_ovf", bus.rsp_ovf, (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000));
`endif
        end

        if (!m_busy) begin
          if (er != 2'b00) begin
            m_busy = 1; m_cyc = 1; m_last = mg; m_id = mg;
            m_op = cur_op[mg];
            acc_cnt[mg]++;
            grant_log.push_back(mg);
          end
        end else if (m_cyc > NPASS && bus.rsp_ready) begin
          if (m_op.has_lit) begin
            check("lit_sum", bus.rsp_sum, m_op.lit_sum);
            check("lit_cout", bus.rsp_cout, m_op.lit_cout);
`ifdef CLA_ADD_SEQ_FLAGS_EN
            check("lit_zero", bus.rsp_zero, m_op.lit_zero);
            check("lit_ovf", bus.rsp_ovf, m_op.lit_ovf);
`endif
          end
          m_busy = 0;
          n_rsp++;
        end else begin
          m_cyc++;
        end
      end
    end
  end

  task automatic present(input int r);
    op_t o;
    if (r == 0) o = q0.pop_front(); else o = q1.pop_front();
    cur_op[r] = o;
    if (r == 0) begin bus.req_a0 = o.a; bus.req_b0 = o.b; end
    else        begin bus.req_a1 = o.a; bus.req_b1 = o.b; end
    bus.req_sub[r]   = o.sub;
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic tick();
    int qs;
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (acc_cnt[r] != seen[r]) begin
        seen[r] = acc_cnt[r];
        bus.req_valid[r] = 1'b0;
      end
      qs = (r == 0) ? q0.size() : q1.size();
      if (!bus.req_valid[r] && qs > 0 && (!rand_gap || $urandom_range(3) != 0)) present(r);
    end
    bus.rsp_ready = (rr_mode == 2) ? 1'($urandom_range(1)) : 1'(rr_mode);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() + q1.size() != 0 || bus.req_valid != 2'b00 || m_busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", n < budget, 1);
  endtask

  initial begin
    int base, cnt0, n, rsp_before;
    bus.req_valid = 2'b00; bus.req_sub = 2'b00; bus.rsp_ready = 1'b0;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    rand_gap = 0; rr_mode = 1;
    m_busy = 0; m_last = 1; m_cyc = 0; n_rsp = 0;
    acc_cnt[0] = 0; acc_cnt[1] = 0; seen[0] = 0; seen[1] = 0;

    // Reset state, with both requests raised to show ready stays low.
    bus.req_valid = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_sum", bus.rsp_sum, 0);
    check("rst_rsp_cout", bus.rsp_cout, 0);
    check("rst_add_a", bus.add_a, 0);
    check("rst_add_cin", bus.add_cin, 0);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;

    // Directed cases with hand-computed results.
    q0.push_back(mk(32'h0000_FFFF, 32'h0000_0001, 0, 1, 32'h0001_0000, 0, 0, 0));
    drain(50);
    q1.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 32'h0000_0000, 1, 1, 0));
    drain(50);
    q0.push_back(mk(32'h0000_0005, 32'h0000_0007, 1, 1, 32'hFFFF_FFFE, 0, 0, 0));
    drain(50);
    q0.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 1, 32'h8000_0000, 0, 0, 1));
    drain(50);

    // Contention: both requesters continuously valid.
    base = grant_log.size();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk($urandom, $urandom, 1'($urandom_range(1)), 0, 0, 0, 0, 0));
      q1.push_back(mk($urandom, $urandom, 1'($urandom_range(1)), 0, 0, 0, 0, 0));
    end
    drain(200);
    check("contention_count", grant_log.size() - base, 8);
    if (grant_log.size() - base == 8) begin
      check("contention_first", grant_log[base], 1);
      cnt0 = 0;
      for (int i = 0; i < 8; i++) begin
        if (i > 0) check("contention_alt", grant_log[base+i] != grant_log[base+i-1], 1);
        if (grant_log[base+i] == 1'b0) cnt0++;
      end
      check("contention_fair", cnt0, 4);
    end

    // Backpressure: response held for 5 cycles with another request waiting.
    rr_mode = 0;
    q0.push_back(mk(32'h1234_0000, 32'h0000_5678, 0, 1, 32'h1234_5678, 0, 0, 0));
    n = 0;
    while (!(m_busy && m_cyc > NPASS) && n < 20) begin tick(); n++; end
    check("bp_reach_done", n < 20, 1);
    q1.push_back(mk(32'h0000_0003, 32'h0000_0003, 1, 1, 32'h0000_0000, 1, 1, 0));
    repeat (5) tick();
    check("bp_hold_valid", bus.rsp_valid, 1);
    check("bp_hold_ready", bus.req_ready, 0);
    rr_mode = 1;
    drain(50);

    // Reset during pass 0: in-flight op is dropped, no response.
    q0.push_back(mk(32'hDEAD_BEEF, 32'h0000_0001, 0, 0, 0, 0, 0, 0));
    n = 0;
    while (!(m_busy && m_cyc == 1) && n < 20) begin tick(); n++; end
    check("rst_reach_pass", n < 20, 1);
    rsp_before = n_rsp;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_rsp_sum", bus.rsp_sum, 0);
    check("mid_rst_rsp_cout", bus.rsp_cout, 0);
    check("mid_rst_add_a", bus.add_a, 0);
    check("mid_rst_add_b", bus.add_b, 0);
    check("mid_rst_add_cin", bus.add_cin, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q0.push_back(mk(32'h1234_5678, 32'h0F0F_0F0F, 0, 1, 32'h2143_6587, 0, 0, 0));
    drain(50);
    check("rst_single_rsp", n_rsp - rsp_before, 1);

    // Randomized traffic with random gaps and random backpressure.
    rr_mode = 2;
    rand_gap = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1) == 0)
        q0.push_back(mk(rnd_operand(), rnd_operand(), 1'($urandom_range(1)), 0, 0, 0, 0, 0));
      else
        q1.push_back(mk(rnd_operand(), rnd_operand(), 1'($urandom_range(1)), 0, 0, 0, 0, 0));
    end
    drain(5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
